// File: rtl/icache_tag_assoc_if.sv
// icache_tag_assoc_if: lookup, refill-write and invalidate bundle between
// the icache FSM (master) and the tag store (slave).
interface icache_tag_assoc_if #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20
);
    logic               q_req;
    logic [INDEX_W-1:0] qindex;
    logic [TAG_W-1:0]   qtag;
    logic               hit;
    logic [WAYS-1:0]    hit_way;
    logic [WAYS-1:0]    victim_way;
    logic               wen;
    logic [INDEX_W-1:0] windex;
    logic [WAYS-1:0]    wway;
    logic [TAG_W-1:0]   wtag;
    logic               valid;
    logic               inv_all;
    logic               busy;
    logic               perr;

    modport master (
        output q_req, qindex, qtag,
        output wen, windex, wway, wtag, valid,
        output inv_all,
        input  hit, hit_way, victim_way, busy, perr
    );

    modport slave (
        input  q_req, qindex, qtag,
        input  wen, windex, wway, wtag, valid,
        input  inv_all,
        output hit, hit_way, victim_way, busy, perr
    );
endinterface

// File: rtl/icache_tag_assoc.sv
// icache_tag_assoc: N-way set-associative icache tag store with tree PLRU.
// Optional parity protection per entry: define ICACHE_TAG_PARITY_EN.
module icache_tag_assoc #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20
) (
    input logic               clk,
    input logic               resetn,
    icache_tag_assoc_if.slave bus
);
    localparam int SETS = 1 << INDEX_W;
    localparam int LVLS = $clog2(WAYS);
    localparam int PW   = WAYS - 1;

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INDEX_W-1:0] cnt;
    logic [INDEX_W-1:0] cnt_nxt;
    logic               busy;

    logic [TAG_W:0]     ent  [WAYS][SETS];
    logic [PW-1:0]      plru [SETS];

    logic [WAYS-1:0]    way_hit;
    logic [WAYS-1:0]    way_inv;
    logic [WAYS-1:0]    way_bad;
    logic [WAYS-1:0]    hit_way;
    logic               touch;
    logic               wr;

    // Lowest set bit of a way mask, as a one-hot mask.
    function automatic logic [WAYS-1:0] lowest_one(input logic [WAYS-1:0] v);
        logic found;
        lowest_one = '0;
        found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (v[i] && !found) begin
                lowest_one[i] = 1'b1;
                found = 1'b1;
            end
        end
    endfunction

    // Way reached by following the tree; a 0 node bit steers to the lower half.
    function automatic logic [WAYS-1:0] tree_victim(input logic [PW-1:0] t);
        logic m;
        tree_victim = '0;
        for (int i = 0; i < WAYS; i++) begin
            m = 1'b1;
            for (int l = 0; l < LVLS; l++) begin
                if (t[(1 << l) - 1 + (i >> (LVLS - l))] !=
                    1'((i >> (LVLS - 1 - l)) & 1)) begin
                    m = 1'b0;
                end
            end
            tree_victim[i] = m;
        end
    endfunction

    // Make way w most recent: every node on its path points away from it.
    function automatic logic [PW-1:0] tree_touch(
        input logic [PW-1:0]   t,
        input logic [WAYS-1:0] w
    );
        tree_touch = t;
        for (int i = 0; i < WAYS; i++) begin
            if (w[i]) begin
                for (int l = 0; l < LVLS; l++) begin
                    tree_touch[(1 << l) - 1 + (i >> (LVLS - l))] =
                        ~1'((i >> (LVLS - 1 - l)) & 1);
                end
            end
        end
    endfunction

    assign busy = (state == SWEEP);

    // State and sweep counter; reset starts a full sweep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep sequencing; inv_all (re)starts the sweep from set 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            SWEEP: begin
                cnt_nxt = cnt + 1'b1;
                if (bus.inv_all) begin
                    cnt_nxt = '0;
                end else if (&cnt) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (bus.inv_all) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

`ifdef ICACHE_TAG_PARITY_EN
    logic par [WAYS][SETS];

    // Even parity over {valid, tag}; cleared entries are all-zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WAYS; i++) begin
            if (busy) begin
                par[i][cnt] <= 1'b0;
            end else if (bus.wen && bus.wway[i]) begin
                par[i][bus.windex] <= ^{bus.valid, bus.wtag};
            end
        end
    end

    // A valid way whose stored parity disagrees is corrupt.
    always_comb begin
        way_bad = '0;
        for (int i = 0; i < WAYS; i++) begin
            way_bad[i] = ent[i][bus.qindex][TAG_W] &&
                         (par[i][bus.qindex] != ^ent[i][bus.qindex]);
        end
    end

    assign bus.perr = bus.q_req && !busy && (|way_bad);
`else
    assign way_bad  = '0;
    assign bus.perr = 1'b0;
`endif

    // Tag/valid storage: sweep clears set cnt, otherwise refill writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WAYS; i++) begin
            if (busy) begin
                ent[i][cnt] <= '0;
            end else if (bus.wen && bus.wway[i]) begin
                ent[i][bus.windex] <= {bus.valid, bus.wtag};
            end
        end
    end

    // Per-way compare against the addressed set.
    always_comb begin
        way_hit = '0;
        way_inv = '0;
        for (int i = 0; i < WAYS; i++) begin
            way_inv[i] = !ent[i][bus.qindex][TAG_W];
            way_hit[i] = ent[i][bus.qindex][TAG_W] &&
                         (ent[i][bus.qindex][TAG_W-1:0] == bus.qtag) &&
                         !way_bad[i];
        end
    end

    assign hit_way        = busy ? '0 : lowest_one(way_hit);
    assign bus.hit_way    = hit_way;
    assign bus.hit        = |hit_way;
    assign bus.busy       = busy;
    assign bus.victim_way = (|way_inv) ? lowest_one(way_inv)
                                       : tree_victim(plru[bus.qindex]);

    assign touch = bus.q_req && (|hit_way);
    assign wr    = bus.wen && !busy;

    // PLRU storage: sweep clears; a write beats a touch on the same set.
    always_ff @(posedge clk) begin
        if (busy) begin
            plru[cnt] <= '0;
        end else begin
            if (touch && !(wr && (bus.windex == bus.qindex))) begin
                plru[bus.qindex] <= tree_touch(plru[bus.qindex], hit_way);
            end
            if (wr) begin
                plru[bus.windex] <= tree_touch(plru[bus.windex], bus.wway);
            end
        end
    end
endmodule

// File: tb/tb_icache_tag_assoc.sv
// tb_icache_tag_assoc: directed and random checks of the tag store
// against a two-way LRU reference model.
module tb_icache_tag_assoc;
    localparam int WAYS    = 2;
    localparam int INDEX_W = 7;
    localparam int TAG_W   = 20;
    localparam int SETS    = 1 << INDEX_W;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    bit               m_v   [SETS][WAYS];
    logic [TAG_W-1:0] m_t   [SETS][WAYS];
    int               m_mru [SETS];

    icache_tag_assoc_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus();

    icache_tag_assoc #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.q_req   = 1'b0;
        bus.qindex  = '0;
        bus.qtag    = '0;
        bus.wen     = 1'b0;
        bus.windex  = '0;
        bus.wway    = 2'b01;
        bus.wtag    = '0;
        bus.valid   = 1'b0;
        bus.inv_all = 1'b0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_mru[s] = -1;
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 1'b0;
                m_t[s][w] = '0;
            end
        end
    endtask

    function automatic int model_hit(input int s, input logic [TAG_W-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] && m_t[s][w] == t) return w;
        return -1;
    endfunction

    function automatic logic [WAYS-1:0] onehot(input int w);
        logic [WAYS-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // Victim: first empty way, otherwise the way not used most recently.
    function automatic logic [WAYS-1:0] model_victim(input int s);
        for (int w = 0; w < WAYS; w++)
            if (!m_v[s][w]) return onehot(w);
        if (m_mru[s] < 0) return onehot(0);
        return onehot(1 - m_mru[s]);
    endfunction

    // Apply this cycle's touch then write, so the write wins on one set.
    task automatic model_edge();
        int hw;
        int ww;
        hw = -1;
        if (bus.q_req) hw = model_hit(int'(bus.qindex), bus.qtag);
        if (hw >= 0) m_mru[bus.qindex] = hw;
        if (bus.wen) begin
            ww = bus.wway[1] ? 1 : 0;
            m_mru[bus.windex]   = ww;
            m_v[bus.windex][ww] = bus.valid;
            m_t[bus.windex][ww] = bus.wtag;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        bus.q_req = 1'b1;
        bus.qindex = 7'd5;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.hit !== 1'b0 || bus.hit_way !== 2'b00) begin
            errors++;
            $display("FAIL reset_state busy=%b hit=%b hit_way=%b want 1 0 00",
                     bus.busy, bus.hit, bus.hit_way);
        end
        checks++;
        if (bus.perr !== 1'b0) begin
            errors++;
            $display("FAIL reset_perr got %b want 0", bus.perr);
        end
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            if (n == 20) begin
                checks++;
                if (bus.hit !== 1'b0 || bus.hit_way !== 2'b00) begin
                    errors++;
                    $display("FAIL sweep_lookup hit=%b hit_way=%b want 0 00",
                             bus.hit, bus.hit_way);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != SETS) begin
            errors++;
            $display("FAIL reset_sweep_len got %0d cycles want %0d", n, SETS);
        end
        @(negedge clk);
        idle_inputs();
        model_clear();
    endtask

    task automatic test_write_hit();
        bus.wen = 1'b1;
        bus.windex = 7'd3;
        bus.wway = 2'b01;
        bus.wtag = 20'hABCDE;
        bus.valid = 1'b1;
        step();
        idle_inputs();
        bus.q_req = 1'b1;
        bus.qindex = 7'd3;
        bus.qtag = 20'hABCDE;
        #1;
        checks++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 2'b01 || bus.victim_way !== 2'b10) begin
            errors++;
            $display("FAIL write_hit hit=%b way=%b victim=%b want 1 01 10",
                     bus.hit, bus.hit_way, bus.victim_way);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_plru();
        bus.wen = 1'b1;
        bus.windex = 7'd3;
        bus.wway = 2'b10;
        bus.wtag = 20'h12345;
        bus.valid = 1'b1;
        step();
        idle_inputs();
        bus.q_req = 1'b1;
        bus.qindex = 7'd3;
        bus.qtag = 20'hABCDE;
        #1;
        checks++;
        if (bus.hit_way !== 2'b01) begin
            errors++;
            $display("FAIL plru_hit0 got %b want 01", bus.hit_way);
        end
        step();
        bus.q_req = 1'b0;
        #1;
        checks++;
        if (bus.victim_way !== 2'b10 || bus.victim_way !== model_victim(3)) begin
            errors++;
            $display("FAIL plru_touch0 victim=%b want 10", bus.victim_way);
        end
        bus.q_req = 1'b1;
        bus.qtag = 20'h12345;
        #1;
        checks++;
        if (bus.hit_way !== 2'b10) begin
            errors++;
            $display("FAIL plru_hit1 got %b want 10", bus.hit_way);
        end
        step();
        bus.q_req = 1'b0;
        #1;
        checks++;
        if (bus.victim_way !== 2'b01 || bus.victim_way !== model_victim(3)) begin
            errors++;
            $display("FAIL plru_touch1 victim=%b want 01", bus.victim_way);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        bus.wen = 1'b1;
        bus.windex = 7'd20;
        bus.wway = 2'b01;
        bus.wtag = 20'h55555;
        bus.valid = 1'b1;
        bus.q_req = 1'b1;
        bus.qindex = 7'd20;
        bus.qtag = 20'h55555;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL collide_same got hit=%b want 0", bus.hit);
        end
        step();
        bus.wen = 1'b0;
        #1;
        checks++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 2'b01) begin
            errors++;
            $display("FAIL collide_next hit=%b way=%b want 1 01",
                     bus.hit, bus.hit_way);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_inv_all();
        int n;
        bus.inv_all = 1'b1;
        step();
        bus.inv_all = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != SETS) begin
            errors++;
            $display("FAIL inv_all_len got %0d cycles want %0d", n, SETS);
        end
        @(negedge clk);
        model_clear();
        bus.q_req = 1'b1;
        bus.qindex = 7'd3;
        bus.qtag = 20'hABCDE;
        #1;
        checks++;
        if (bus.hit !== 1'b0 || bus.victim_way !== 2'b01) begin
            errors++;
            $display("FAIL inv_all_after hit=%b victim=%b want 0 01",
                     bus.hit, bus.victim_way);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        bus.inv_all = 1'b1;
        step();
        bus.inv_all = 1'b0;
        repeat (50) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != SETS) begin
            errors++;
            $display("FAIL mid_reset_len got %0d cycles want %0d", n, SETS);
        end
        @(negedge clk);
        model_clear();
        idle_inputs();
    endtask

    task automatic test_random();
        int hw;
        logic [WAYS-1:0] ehw;
        logic [WAYS-1:0] evic;
        for (int c = 0; c < 600; c++) begin
            bus.q_req  = ($urandom_range(0, 9) < 7);
            bus.qindex = 7'($urandom_range(0, 3));
            bus.qtag   = 20'($urandom_range(0, 3));
            bus.wen    = ($urandom_range(0, 9) < 4);
            bus.windex = 7'($urandom_range(0, 3));
            bus.wway   = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            bus.wtag   = 20'($urandom_range(0, 3));
            bus.valid  = ($urandom_range(0, 3) != 0);
            #1;
            hw   = model_hit(int'(bus.qindex), bus.qtag);
            ehw  = onehot(hw);
            evic = model_victim(int'(bus.qindex));
            checks++;
            if (bus.hit !== (hw >= 0) || bus.hit_way !== ehw ||
                bus.victim_way !== evic || bus.busy !== 1'b0 ||
                bus.perr !== 1'b0) begin
                errors++;
                $display("FAIL random c=%0d set=%0d hit=%b way=%b vic=%b want %b %b %b",
                         c, bus.qindex, bus.hit, bus.hit_way, bus.victim_way,
                         (hw >= 0), ehw, evic);
            end
            step();
        end
        idle_inputs();
    endtask

`ifdef ICACHE_TAG_PARITY_EN
    task automatic test_parity();
        bus.wen = 1'b1;
        bus.windex = 7'd9;
        bus.wway = 2'b10;
        bus.wtag = 20'h0F0F0;
        bus.valid = 1'b1;
        step();
        idle_inputs();
        dut.ent[1][9][0] = ~dut.ent[1][9][0];
        bus.q_req = 1'b1;
        bus.qindex = 7'd9;
        bus.qtag = 20'h0F0F1;
        #1;
        checks++;
        if (bus.hit !== 1'b0 || bus.perr !== 1'b1) begin
            errors++;
            $display("FAIL parity hit=%b perr=%b want 0 1", bus.hit, bus.perr);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        test_reset();
        test_write_hit();
        test_plru();
        test_collision();
        test_inv_all();
        test_reset_mid_sweep();
        test_random();
`ifdef ICACHE_TAG_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
